// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the stall sequencer, the hazard unit / data memory
// and the pipeline registers it enables, bubbles and flushes.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             Hazard_Req;
  logic             Branch_Taken;
  logic             Mem_Req;
  logic             Mem_Ready;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             EXMEM_Write;
  logic             MEMWB_Bubble;
  logic             Timeout;
  logic [CNT_W-1:0] Stall_Count;

  modport master (
    output Hazard_Req, Branch_Taken, Mem_Req, Mem_Ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble,
    input  Timeout, Stall_Count
  );

  modport slave (
    input  Hazard_Req, Branch_Taken, Mem_Req, Mem_Ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble,
    output Timeout, Stall_Count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory-wait freeze,
// load-use bubble, branch flush shadow, memory timeout and a stall counter.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT  = 255,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave ctl
);
  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_s;
  logic [FLUSH_W-1:0] flush_cnt_r, flush_cnt_s;
  logic               timeout_r, timeout_s;
  logic [CNT_W-1:0]   stall_cnt_r;

  logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, exmem_write_s, memwb_bubble_s;
  logic mem_stall_s;

  assign mem_stall_s = ctl.Mem_Req & ~ctl.Mem_Ready;

  // Next-state and same-cycle control decode; memory stall outranks hazard outranks branch.
  always_comb begin
    state_s        = state_r;
    wait_cnt_s     = wait_cnt_r;
    flush_cnt_s    = flush_cnt_r;
    timeout_s      = timeout_r;
    pc_write_s     = 1'b1;
    ifid_write_s   = 1'b1;
    exmem_write_s  = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    memwb_bubble_s = 1'b0;

    case (state_r)
      RUN, FLUSH: begin
        if (mem_stall_s) begin
          pc_write_s     = 1'b0;
          ifid_write_s   = 1'b0;
          exmem_write_s  = 1'b0;
          memwb_bubble_s = 1'b1;
          state_s        = MEM_WAIT;
          wait_cnt_s     = WAIT_W'(1);
        end else if (state_r == FLUSH) begin
          ifid_flush_s = 1'b1;
          if (flush_cnt_r > FLUSH_W'(1)) begin
            flush_cnt_s = flush_cnt_r - FLUSH_W'(1);
          end else begin
            flush_cnt_s = {FLUSH_W{1'b0}};
            state_s     = RUN;
          end
        end else if (ctl.Hazard_Req) begin
          pc_write_s    = 1'b0;
          ifid_write_s  = 1'b0;
          idex_bubble_s = 1'b1;
        end else if (ctl.Branch_Taken) begin
          ifid_flush_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_s     = FLUSH;
            flush_cnt_s = FLUSH_W'(FLUSH_CYCLES - 1);
          end else begin
            flush_cnt_s = {FLUSH_W{1'b0}};
          end
        end else begin
          state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (ctl.Mem_Ready) begin
          wait_cnt_s = {WAIT_W{1'b0}};
          state_s    = (flush_cnt_r != {FLUSH_W{1'b0}}) ? FLUSH : RUN;
        end else begin
          pc_write_s     = 1'b0;
          ifid_write_s   = 1'b0;
          exmem_write_s  = 1'b0;
          memwb_bubble_s = 1'b1;
          if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
            state_s   = ERROR;
            timeout_s = 1'b1;
          end else begin
            wait_cnt_s = wait_cnt_r + WAIT_W'(1);
          end
        end
      end
      ERROR: begin
        pc_write_s    = 1'b0;
        ifid_write_s  = 1'b0;
        exmem_write_s = 1'b0;
        timeout_s     = 1'b1;
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // State, counters and sticky timeout; reset abandons any wait or flush in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      flush_cnt_r <= {FLUSH_W{1'b0}};
      timeout_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      flush_cnt_r <= flush_cnt_s;
      timeout_r   <= timeout_s;
      if (!pc_write_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  assign ctl.PC_Write     = pc_write_s     & ~reset;
  assign ctl.IFID_Write   = ifid_write_s   & ~reset;
  assign ctl.EXMEM_Write  = exmem_write_s  & ~reset;
  assign ctl.IFID_Flush   = ifid_flush_s   & ~reset;
  assign ctl.IDEX_Bubble  = idex_bubble_s  & ~reset;
  assign ctl.MEMWB_Bubble = memwb_bubble_s & ~reset;
  assign ctl.Timeout      = timeout_r;
  assign ctl.Stall_Count  = stall_cnt_r;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;
  localparam int MEM_TIMEOUT  = 4;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 5;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // control vector order: {PC_Write, IFID_Write, EXMEM_Write, IFID_Flush, IDEX_Bubble, MEMWB_Bubble}
  localparam logic [5:0] V_RUN = 6'b111_000;
  localparam logic [5:0] V_HAZ = 6'b001_010;
  localparam logic [5:0] V_FRZ = 6'b000_001;
  localparam logic [5:0] V_FLS = 6'b111_100;
  localparam logic [5:0] V_OFF = 6'b000_000;

  logic clk;
  logic reset;
  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) itf ();

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ctl  (itf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit m_error, m_waiting, m_timeout;
  int m_wait_n, m_flush_left, m_stalls;

  logic [5:0]       obs_ctl, exp_ctl;
  logic             obs_to, exp_to;
  logic [CNT_W-1:0] obs_cnt, exp_cnt;

  // Drive one cycle, sample combinational controls mid-cycle, then registered outputs after the edge.
  task automatic step(input logic h, input logic b, input logic mq, input logic mr, input logic rst);
    logic [5:0] e;
    itf.Hazard_Req   = h;
    itf.Branch_Taken = b;
    itf.Mem_Req      = mq;
    itf.Mem_Ready    = mr;
    reset            = rst;
    #3;
    obs_ctl = {itf.PC_Write, itf.IFID_Write, itf.EXMEM_Write,
               itf.IFID_Flush, itf.IDEX_Bubble, itf.MEMWB_Bubble};
    e = V_OFF;
    if (rst) begin
      m_error = 0; m_waiting = 0; m_timeout = 0;
      m_wait_n = 0; m_flush_left = 0; m_stalls = 0;
    end else begin
      if (m_error) begin
        e = V_OFF;
      end else if (m_waiting) begin
        if (mr) begin
          e = V_RUN;
          m_waiting = 0;
        end else begin
          e = V_FRZ;
          m_wait_n++;
          if (m_wait_n == MEM_TIMEOUT) begin
            m_error = 1; m_timeout = 1; m_waiting = 0;
          end
        end
      end else if (mq && !mr) begin
        e = V_FRZ;
        m_waiting = 1;
        m_wait_n = 0;
      end else if (m_flush_left > 0) begin
        e = V_FLS;
        m_flush_left--;
      end else if (h) begin
        e = V_HAZ;
      end else if (b) begin
        e = V_FLS;
        m_flush_left = FLUSH_CYCLES - 1;
      end else begin
        e = V_RUN;
      end
      if (e[5] == 1'b0 && m_stalls < CNT_MAX) m_stalls++;
    end
    exp_ctl = e;
    @(posedge clk);
    #1;
    obs_to  = itf.Timeout;
    obs_cnt = itf.Stall_Count;
    exp_to  = m_timeout;
    exp_cnt = CNT_W'(m_stalls);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1);
      n_checks++;
      if (obs_ctl !== V_OFF) begin n_errors++; $display("FAIL reset_ctl: got %b expected %b", obs_ctl, V_OFF); end
    end
    n_checks++;
    if (obs_to !== 1'b0 || obs_cnt !== '0) begin
      n_errors++; $display("FAIL reset_regs: got to=%b cnt=%0d expected to=0 cnt=0", obs_to, obs_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if (obs_ctl !== V_RUN || obs_cnt !== '0 || obs_to !== 1'b0) begin
        n_errors++; $display("FAIL idle: got ctl=%b cnt=%0d to=%b expected ctl=%b cnt=0 to=0", obs_ctl, obs_cnt, obs_to, V_RUN);
      end
    end
  endtask

  task automatic test_hazard();
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (obs_ctl !== V_HAZ || obs_cnt !== 5'd1) begin
      n_errors++; $display("FAIL hazard: got ctl=%b cnt=%0d expected ctl=%b cnt=1", obs_ctl, obs_cnt, V_HAZ);
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ctl !== V_RUN) begin n_errors++; $display("FAIL hazard_after: got %b expected %b", obs_ctl, V_RUN); end
  endtask

  task automatic test_mem_wait();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      n_checks++;
      if (obs_ctl !== V_FRZ) begin n_errors++; $display("FAIL mem_freeze%0d: got %b expected %b", i, obs_ctl, V_FRZ); end
    end
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (obs_ctl !== V_RUN || obs_cnt !== 5'd3) begin
      n_errors++; $display("FAIL mem_release: got ctl=%b cnt=%0d expected ctl=%b cnt=3", obs_ctl, obs_cnt, V_RUN);
    end
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (obs_ctl !== V_RUN) begin n_errors++; $display("FAIL mem_ready_same: got %b expected %b", obs_ctl, V_RUN); end
  endtask

  task automatic test_branch_flush();
    logic [5:0] want [7];
    want = '{V_FLS, V_FRZ, V_FRZ, V_RUN, V_FLS, V_FLS, V_RUN};
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (obs_ctl !== want[0]) begin n_errors++; $display("FAIL flush_0: got %b expected %b", obs_ctl, want[0]); end
    step(1, 1, 1, 0, 0);
    n_checks++;
    if (obs_ctl !== want[1]) begin n_errors++; $display("FAIL flush_1: got %b expected %b", obs_ctl, want[1]); end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (obs_ctl !== want[2]) begin n_errors++; $display("FAIL flush_2: got %b expected %b", obs_ctl, want[2]); end
    step(0, 0, 1, 1, 0);
    n_checks++;
    if (obs_ctl !== want[3]) begin n_errors++; $display("FAIL flush_3: got %b expected %b", obs_ctl, want[3]); end
    for (int i = 4; i < 7; i++) begin
      step(1, 1, 0, 0, 0);
      if (i == 6) step(0, 0, 0, 0, 0);
      n_checks++;
      if (obs_ctl !== want[i]) begin n_errors++; $display("FAIL flush_%0d: got %b expected %b", i, obs_ctl, want[i]); end
    end
    // a reset inside the flush shadow must leave no residual flush
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ctl !== V_RUN) begin n_errors++; $display("FAIL flush_abort: got %b expected %b", obs_ctl, V_RUN); end
  endtask

  task automatic test_timeout();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0);
      n_checks++;
      if (obs_ctl !== V_FRZ || obs_to !== (i == 4)) begin
        n_errors++; $display("FAIL timeout_wait%0d: got ctl=%b to=%b expected ctl=%b to=%b", i, obs_ctl, obs_to, V_FRZ, (i == 4));
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(1, 1, 1, 1, 0);
      n_checks++;
      if (obs_ctl !== V_OFF || obs_to !== 1'b1) begin
        n_errors++; $display("FAIL error_state%0d: got ctl=%b to=%b expected ctl=%b to=1", i, obs_ctl, obs_to, V_OFF);
      end
    end
    n_checks++;
    if (obs_cnt !== 5'd31) begin n_errors++; $display("FAIL stall_sat: got %0d expected 31", obs_cnt); end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ctl !== V_RUN || obs_to !== 1'b0 || obs_cnt !== '0) begin
      n_errors++; $display("FAIL timeout_restart: got ctl=%b to=%b cnt=%0d expected ctl=%b to=0 cnt=0", obs_ctl, obs_to, obs_cnt, V_RUN);
    end
  endtask

  task automatic test_priority();
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0);
    n_checks++;
    if (obs_ctl !== V_FRZ) begin n_errors++; $display("FAIL prio_freeze: got %b expected %b", obs_ctl, V_FRZ); end
    step(1, 1, 1, 1, 0);
    n_checks++;
    if (obs_ctl !== V_RUN) begin n_errors++; $display("FAIL prio_release: got %b expected %b", obs_ctl, V_RUN); end
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ctl !== V_RUN || obs_cnt !== '0) begin
      n_errors++; $display("FAIL wait_abort: got ctl=%b cnt=%0d expected ctl=%b cnt=0", obs_ctl, obs_cnt, V_RUN);
    end
  endtask

  task automatic test_random();
    logic h, b, mq, mr, rst;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      h   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 3) == 0);
      mq  = ($urandom_range(0, 1) == 0);
      mr  = ($urandom_range(0, 9) < 6);
      step(h, b, mq, mr, rst);
      n_checks++;
      if (obs_ctl !== exp_ctl || obs_to !== exp_to || obs_cnt !== exp_cnt) begin
        n_errors++;
        $display("FAIL random%0d: got ctl=%b to=%b cnt=%0d expected ctl=%b to=%b cnt=%0d",
                 i, obs_ctl, obs_to, obs_cnt, exp_ctl, exp_to, exp_cnt);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    itf.Hazard_Req   = 1'b0;
    itf.Branch_Taken = 1'b0;
    itf.Mem_Req      = 1'b0;
    itf.Mem_Ready    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_hazard();
    test_mem_wait();
    test_branch_flush();
    test_timeout();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
